// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer
//   FIFO write buffer between MEM stage and data memory, with youngest-match
//   store-to-load forwarding and a starvation-guarded single memory port.
//   Revision: 1.0
// ============================================================================
module store_buffer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   st_valid_i,
  input  logic [31:0]            st_addr_i,
  input  logic [31:0]            st_data_i,
  output logic                   st_ready_o,
  input  logic                   ld_req_i,
  input  logic [31:0]            ld_addr_i,
  output logic [31:0]            ld_data_o,
  output logic                   ld_hit_o,
  output logic                   ld_stall_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_data_o,
  output logic                   mem_write_o,
  output logic                   mem_read_o,
  input  logic [31:0]            mem_data_i,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_DEPTH        = CW'(DEPTH);
  localparam logic [SW-1:0] C_STARVE_LIMIT = SW'(STARVE_LIMIT);

  logic          ent_valid [DEPTH];
  logic [31:0]   ent_addr  [DEPTH];
  logic [31:0]   ent_data  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic          hit;
  logic [31:0]   hit_data;
  logic [PW-1:0] slot;
  logic          empty;
  logic          enq;
  logic          force_drain;
  logic          drain;

  // Walk entries oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (ld_req_i && ent_valid[slot] && (ent_addr[slot] == ld_addr_i)) begin
        hit      = 1'b1;
        hit_data = ent_data[slot];
      end
    end
  end

  assign empty       = (count == '0);
  assign st_ready_o  = (count < C_DEPTH);
  assign enq         = st_valid_i & st_ready_o;
  assign force_drain = ~empty & (starve == C_STARVE_LIMIT);
  assign drain       = ent_valid[head] & (~ld_req_i | hit | force_drain);

  // Memory port: a drain owns it whenever it happens; otherwise a load miss reads.
  assign mem_write_o = drain;
  assign mem_read_o  = ld_req_i & ~hit & ~force_drain;
  assign mem_addr_o  = drain ? ent_addr[head] : (mem_read_o ? ld_addr_i : '0);
  assign mem_data_o  = drain ? ent_data[head] : '0;

  assign ld_hit_o   = hit;
  assign ld_stall_o = ld_req_i & ~hit & force_drain;
  assign ld_data_o  = ~ld_req_i ? '0 : (hit ? hit_data : mem_data_i);

  assign empty_o = empty;
  assign count_o = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      starve <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
    end else begin
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      count <= count + CW'(enq) - CW'(drain);
      if (drain || empty) begin
        starve <= '0;
      end else if (ld_req_i && !hit && !force_drain) begin
        starve <= starve + SW'(1);
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      ent_addr[tail] <= st_addr_i;
      ent_data[tail] <= st_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// tb_store_buffer: directed stimulus checked against a queue-based
// reference model plus hand-computed literal expectations.
module tb_store_buffer;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic        st_ready_o;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_o;
  logic        ld_hit_o;
  logic        ld_stall_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_data_i;
  logic        empty_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [64];
  logic [31:0] exp_mem [64];

  store_buffer #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_ready_o(st_ready_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_data_o(ld_data_o),
    .ld_hit_o(ld_hit_o), .ld_stall_o(ld_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_data_i(mem_data_i),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory seen by the DUT.
  assign mem_data_i = mem[mem_addr_o[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[12] = 32'h0000_1234;
    forever begin
      @(posedge clk);
      if (mem_write_o) mem[mem_addr_o[7:2]] <= mem_data_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending stores, a blocked-cycle counter and
  // the memory image implied by the stores retired so far.
  initial begin : model
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    int          starve_m;
    bit          model_on;
    bit          hit, frc, drn, rdq, stall, full, emp;
    logic [31:0] hd, a0, exp_ld;
    bit          s_v, s_rst;
    logic [31:0] s_a, s_d;
    starve_m = 0;
    model_on = 0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'hA000_0000 | 32'(i);
    exp_mem[12] = 32'h0000_1234;
    forever begin
      @(negedge clk);
      emp = (qa.size() == 0);
      full = (qa.size() == DEPTH);
      hit = 0;
      hd  = '0;
      if (ld_req_i) begin
        for (int i = qa.size() - 1; i >= 0; i--) begin
          if (qa[i] == ld_addr_i) begin
            hit = 1;
            hd  = qd[i];
            break;
          end
        end
      end
      frc   = !emp && (starve_m == STARVE_LIMIT);
      drn   = !emp && (!ld_req_i || hit || frc);
      rdq   = ld_req_i && !hit && !frc;
      stall = ld_req_i && !hit && frc;
      exp_ld = !ld_req_i ? 32'h0 : (hit ? hd : exp_mem[ld_addr_i[7:2]]);
      if (model_on) begin
        chk("m_st_ready",  32'(st_ready_o),  32'(!full));
        chk("m_count",     32'(count_o),     32'(qa.size()));
        chk("m_empty",     32'(empty_o),     32'(emp));
        chk("m_mem_write", 32'(mem_write_o), 32'(drn));
        chk("m_mem_read",  32'(mem_read_o),  32'(rdq));
        chk("m_ld_hit",    32'(ld_hit_o),    32'(hit));
        chk("m_ld_stall",  32'(ld_stall_o),  32'(stall));
        if (drn) begin
          chk("m_wr_addr", mem_addr_o, qa[0]);
          chk("m_wr_data", mem_data_o, qd[0]);
        end else if (rdq) begin
          chk("m_rd_addr", mem_addr_o, ld_addr_i);
        end
        if (!stall) chk("m_ld_data", ld_data_o, exp_ld);
      end
      s_v   = st_valid_i;
      s_a   = st_addr_i;
      s_d   = st_data_i;
      s_rst = rst;
      @(posedge clk);
      if (model_on && drn) begin
        a0 = qa[0];
        exp_mem[a0[7:2]] = qd[0];
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (s_rst) begin
        qa.delete();
        qd.delete();
        starve_m = 0;
        model_on = 1;
      end else if (model_on) begin
        if (s_v && !full) begin
          qa.push_back(s_a);
          qd.push_back(s_d);
        end
        if (drn || emp) starve_m = 0;
        else if (rdq) starve_m++;
      end
    end
  end

  task automatic drive(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input bit lr, input logic [31:0] la);
    st_valid_i = sv;
    st_addr_i  = sa;
    st_data_i  = sd;
    ld_req_i   = lr;
    ld_addr_i  = la;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    bit seen;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("r_st_ready",  32'(st_ready_o),  1);
    chk("r_empty",     32'(empty_o),     1);
    chk("r_count",     32'(count_o),     0);
    chk("r_mem_write", 32'(mem_write_o), 0);
    chk("r_mem_read",  32'(mem_read_o),  0);
    chk("r_ld_hit",    32'(ld_hit_o),    0);
    chk("r_ld_stall",  32'(ld_stall_o),  0);
    chk("r_ld_data",   ld_data_o,        0);
    step();

    // Single store retires in the following cycle
    drive(1, 32'h10, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    chk("t1_ready", 32'(st_ready_o), 1);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_count", 32'(count_o), 1);
    chk("t1_wr",    32'(mem_write_o), 1);
    chk("t1_addr",  mem_addr_o, 32'h10);
    chk("t1_data",  mem_data_o, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1_empty", 32'(empty_o), 1);
    step();

    // Continuous missing loads: drain forced after STARVE_LIMIT blocked cycles
    drive(1, 32'h10, 32'hDEADBEEF, 1, 32'h40);
    @(negedge clk);
    chk("t2_rd", 32'(mem_read_o), 1);
    step();
    drive(1, 32'h14, 32'h2, 1, 32'h40);
    @(negedge clk);
    chk("t2_blocked0", 32'(mem_write_o), 0);
    step();
    drive(0, 0, 0, 1, 32'h40);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t2_blocked", 32'(mem_write_o), 0);
      step();
    end
    @(negedge clk);
    chk("t2_stall",      32'(ld_stall_o),  1);
    chk("t2_force_wr",   32'(mem_write_o), 1);
    chk("t2_force_addr", mem_addr_o,       32'h10);
    chk("t2_force_rd",   32'(mem_read_o),  0);
    step();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_write_o) begin
        seen = 1;
        chk("t2_force2_addr",  mem_addr_o,      32'h14);
        chk("t2_force2_stall", 32'(ld_stall_o), 1);
      end
      step();
    end
    if (!seen) chk("t2_force2_timeout", 0, 1);
    drive(0, 0, 0, 0, 0);
    step();

    // Youngest-match forwarding while the head drains
    drive(1, 32'h20, 32'h1, 1, 32'h40);
    step();
    drive(1, 32'h20, 32'h2, 1, 32'h40);
    step();
    drive(0, 0, 0, 1, 32'h20);
    @(negedge clk);
    chk("t3_hit",   32'(ld_hit_o),    1);
    chk("t3_data",  ld_data_o,        32'h2);
    chk("t3_rd",    32'(mem_read_o),  0);
    chk("t3_wr",    32'(mem_write_o), 1);
    chk("t3_addr",  mem_addr_o,       32'h20);
    chk("t3_wdata", mem_data_o,       32'h1);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_wr2",    32'(mem_write_o), 1);
    chk("t3_wdata2", mem_data_o,       32'h2);
    step();

    // Fill to full, refuse a fifth store, then drain in FIFO order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h50 + 32'(4 * i), 32'h11 * 32'(i + 1), 1, 32'h40);
      step();
    end
    drive(1, 32'h60, 32'h55, 1, 32'h40);
    @(negedge clk);
    chk("t4_full_ready", 32'(st_ready_o), 0);
    chk("t4_full_count", 32'(count_o),    4);
    step();
    drive(1, 32'h60, 32'h55, 0, 0);
    @(negedge clk);
    chk("t4_ready_full", 32'(st_ready_o), 0);
    chk("t4_wr0_addr",   mem_addr_o,      32'h50);
    step();
    @(negedge clk);
    chk("t4_ready_again", 32'(st_ready_o), 1);
    chk("t4_wr1_addr",    mem_addr_o,      32'h54);
    step();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_wr2_addr", mem_addr_o, 32'h58);
    step();
    @(negedge clk);
    chk("t4_wr3_addr", mem_addr_o, 32'h5C);
    step();
    @(negedge clk);
    chk("t4_wr4_addr", mem_addr_o, 32'h60);
    chk("t4_wr4_data", mem_data_o, 32'h55);
    step();
    @(negedge clk);
    chk("t4_empty", 32'(empty_o), 1);
    step();

    // Load miss with empty buffer reads memory
    drive(0, 0, 0, 1, 32'h30);
    @(negedge clk);
    chk("t5_rd",    32'(mem_read_o), 1);
    chk("t5_data",  ld_data_o,       32'h1234);
    chk("t5_hit",   32'(ld_hit_o),   0);
    chk("t5_stall", 32'(ld_stall_o), 0);
    step();

    // Reset discards buffered stores
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h70 + 32'(4 * i), 32'h700 + 32'(i), 1, 32'h40);
      step();
    end
    drive(0, 0, 0, 1, 32'h40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_count", 32'(count_o),     0);
    chk("t6_empty", 32'(empty_o),     1);
    chk("t6_wr",    32'(mem_write_o), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_wr", 32'(mem_write_o), 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the MEM pipeline stage and the word-addressed data memory.
- Retires stores to memory in the background so sw instructions never wait on the memory port.
- Serves lw from buffered data when the address matches (store-to-load forwarding); otherwise passes the load through to memory.
- Owns the single data-memory port: arbitrates load reads vs buffer drains, with a starvation guard.

Parameters:
- DEPTH, 4, number of buffered stores (power of 2, >=2).
- STARVE_LIMIT, 8, consecutive blocked-drain cycles before a drain is forced.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- st_valid_i  in  1  store request from MEM stage.
- st_addr_i  in  32  store byte address, word aligned.
- st_data_i  in  32  store data.
- st_ready_o  out  1  buffer can accept a store this cycle.
- ld_req_i  in  1  load request from MEM stage.
- ld_addr_i  in  32  load byte address, word aligned.
- ld_data_o  out  32  load result, combinational.
- ld_hit_o  out  1  load served from buffer this cycle.
- ld_stall_o  out  1  load not served this cycle; MEM stage must hold it.
- mem_addr_o  out  32  address to data memory.
- mem_data_o  out  32  write data to data memory.
- mem_write_o  out  1  data-memory write enable.
- mem_read_o  out  1  data-memory read enable.
- mem_data_i  in  32  read data from data memory (combinational).
- empty_o  out  1  no buffered stores.
- count_o  out  $clog2(DEPTH)+1  number of buffered stores.

Behaviour:
- Reset (rst_i=1 at posedge): head/tail pointers, count and starvation counter go to 0; all entry valid bits cleared.
  - Outputs after reset: st_ready_o=1, empty_o=1, count_o=0, mem_write_o=0, mem_read_o=0, ld_hit_o=0, ld_stall_o=0, ld_data_o=0.
  - Reset mid-drain discards every buffered store.
- Storage: circular array of DEPTH entries {valid, addr[31:0], data[31:0]}. Full address compare; addr[1:0] is stored but not interpreted.
- st_ready_o = (count < DEPTH), from registered count only; no combinational path from ld_req_i.
- Enqueue: st_valid_i & st_ready_o at posedge writes the tail entry and advances tail.
- st_valid_i while full: the store is not taken; the MEM stage must hold it.
- Forwarding (combinational):
  - hit = ld_req_i & any valid entry with addr == ld_addr_i.
  - With multiple matches, the youngest (closest to tail) wins.
  - On hit: ld_hit_o=1, ld_data_o = entry data, mem_read_o=0.
- Load miss: mem_read_o=1, mem_addr_o=ld_addr_i, ld_data_o=mem_data_i, ld_hit_o=0.
- No ld_req_i: ld_data_o=0.
- Drain candidate: head entry valid and (~ld_req_i | hit | force).
  - On drain: mem_write_o=1, mem_addr_o/mem_data_o = head addr/data.
  - Head pops at the same posedge at which memory captures the write.
  - At most one drain per cycle.
- Starvation counter:
  - Increments each cycle with ~empty & ld_req_i & ~hit & ~force.
  - Clears on any drain or when empty.
  - force = (counter == STARVE_LIMIT).
  - On a force cycle: the drain wins the port, mem_read_o=0, ld_stall_o=1 (even on a would-be miss), and the counter clears.
- Simultaneous enqueue and drain: allowed when not full; count unchanged.
- Full: no enqueue is taken in that cycle, even if a drain occurs in the same cycle.
- Pointers wrap modulo DEPTH; empty_o = (count==0).
- st_valid_i and ld_req_i are never asserted together (one MEM instruction per cycle).
  - If they are, the store is enqueued and the load is handled normally.
  - The load does not see the same-cycle store.
- mem_write_o and mem_read_o are never both 1.

Test Plan:
- Reset, then sw 0x10<=0xDEADBEEF with no loads -> st_ready_o=1; count_o=1 for one cycle; next cycle mem_write_o=1, mem_addr_o=0x10, mem_data_o=0xDEADBEEF; then empty_o=1.
- With ld_req_i held at 0x40 (miss) every cycle, sw 0x10<=0xDEADBEEF and sw 0x14<=2 -> no drain for 8 cycles; 9th cycle ld_stall_o=1, mem_write_o=1 to 0x10; a later blocked cycle forces the drain of 0x14.
- sw 0x20<=1, then sw 0x20<=2 while loads block the drain, then lw 0x20 -> ld_hit_o=1, ld_data_o=2, mem_read_o=0; the same cycle drains head (0x20<=1).
- Fill 4 stores while loads block the drain -> st_ready_o=0 and a 5th st_valid_i is not taken; release loads -> 4 writes in FIFO order, tail wraps, then a 5th store accepted.
- lw 0x30 with memory holding 0x1234 and buffer empty -> mem_read_o=1, ld_data_o=0x1234, ld_hit_o=0, ld_stall_o=0.
- Reset asserted with 3 entries buffered -> next cycle count_o=0, empty_o=1, no mem_write_o pulses follow.
